// File: rtl/probe_disp_pkg.sv
// Shared definitions for the probe display path.
// Provides:
//   - active-low gfedcba seven-segment patterns for hex digits, plus blank
//   - hex7seg(): nibble to segment pattern
//   - clog2_min1(): select/index width helper that never returns 0
package probe_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex7seg(input logic [3:0] nibble);
        logic [6:0] pat;
        unique case (nibble)
            4'h0: pat = SEG_0;
            4'h1: pat = SEG_1;
            4'h2: pat = SEG_2;
            4'h3: pat = SEG_3;
            4'h4: pat = SEG_4;
            4'h5: pat = SEG_5;
            4'h6: pat = SEG_6;
            4'h7: pat = SEG_7;
            4'h8: pat = SEG_8;
            4'h9: pat = SEG_9;
            4'hA: pat = SEG_A;
            4'hB: pat = SEG_B;
            4'hC: pat = SEG_C;
            4'hD: pat = SEG_D;
            4'hE: pat = SEG_E;
            default: pat = SEG_F;
        endcase
        return pat;
    endfunction

    // $clog2 gives 0 for n=1; a select still needs one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/probe_display_ctrl_scan_timer.sv
// Digit scan timer: prescaler plus digit index.
// Ports:
//   clk, rst    board clock, synchronous active-high reset
//   tick        one-cycle strobe every REFRESH_DIV cycles
//   d           digit index currently being scanned
//   frame_wrap  tick that starts a new frame (digit index returns to 0)
module scan_timer
    import probe_disp_pkg::*;
#(
    parameter  int unsigned REFRESH_DIV = 50000,
    parameter  int unsigned N_DIGITS    = 4,
    localparam int unsigned PW          = clog2_min1(REFRESH_DIV),
    localparam int unsigned DW          = clog2_min1(N_DIGITS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          tick,
    output logic [DW-1:0] d,
    output logic          frame_wrap
);

    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] digit_q, digit_d;
    logic          started_q, started_d;

    always_comb begin
        tick       = (presc_q == PW'(REFRESH_DIV - 1));
        // The first tick after reset opens a frame without advancing the
        // digit, so the first frame starts on digit 0.
        frame_wrap = tick && (!started_q || (digit_q == DW'(N_DIGITS - 1)));
        presc_d    = tick ? '0 : presc_q + 1'b1;
        digit_d    = digit_q;
        started_d  = started_q;
        if (tick) begin
            started_d = 1'b1;
            digit_d   = frame_wrap ? '0 : digit_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            digit_q   <= '0;
            started_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            digit_q   <= digit_d;
            started_q <= started_d;
        end
    end

    assign d = digit_q;

endmodule

// File: rtl/probe_display_ctrl.sv
// Multi-channel hex display scanner for pipeline probe words.
// Ports:
//   clk, rst     board clock, synchronous active-high reset
//   ch_data      N_CH probe words, channel c at [c*D_SIZE +: D_SIZE]
//   ch_sel       manual channel select (out of range shows channel 0)
//   win_sel      manual window select, window 0 = least significant
//   auto_en      auto-scroll windows every HOLD_FRAMES frames
//   auto_ch      in auto mode, advance channel after the last window
//   freeze       hold the captured snapshot
//   seg          segments gfedcba, active-low
//   an           digit enables, active-low one-hot, an[0] = rightmost
//   cur_ch       channel being displayed
//   cur_win      window being displayed
//   frame_start  one-cycle pulse when digit 0 is first driven in a frame
module probe_display_ctrl
    import probe_disp_pkg::*;
#(
    parameter  int unsigned D_SIZE      = 32,
    parameter  int unsigned N_CH        = 4,
    parameter  int unsigned N_DIGITS    = 4,
    parameter  int unsigned REFRESH_DIV = 50000,
    parameter  int unsigned HOLD_FRAMES = 256,
    localparam int unsigned N_WIN       = D_SIZE / (4 * N_DIGITS),
    localparam int unsigned CH_W        = clog2_min1(N_CH),
    localparam int unsigned WIN_W       = clog2_min1(N_WIN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*D_SIZE-1:0] ch_data,
    input  logic [CH_W-1:0]        ch_sel,
    input  logic [WIN_W-1:0]       win_sel,
    input  logic                   auto_en,
    input  logic                   auto_ch,
    input  logic                   freeze,
    output logic [6:0]             seg,
    output logic [N_DIGITS-1:0]    an,
    output logic [CH_W-1:0]        cur_ch,
    output logic [WIN_W-1:0]       cur_win,
    output logic                   frame_start
);

    localparam int unsigned DIG_W = clog2_min1(N_DIGITS);
    localparam int unsigned FC_W  = clog2_min1(HOLD_FRAMES);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(N_WIN - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(HOLD_FRAMES - 1);

    logic             tick;
    logic [DIG_W-1:0] d;
    logic             frame_wrap;
    logic             boundary;

    scan_timer #(
        .REFRESH_DIV(REFRESH_DIV),
        .N_DIGITS   (N_DIGITS)
    ) u_scan_timer (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .d         (d),
        .frame_wrap(frame_wrap)
    );

    logic [D_SIZE-1:0]   snap_q, snap_d;
    logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
    logic [WIN_W-1:0]    cur_win_q, cur_win_d;
    logic [FC_W-1:0]     fc_q, fc_d;
    logic                auto_prev_q, auto_prev_d;
    logic                active_q, active_d;
    logic                bnd_q, bnd_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                fs_q, fs_d;

    int unsigned         nib_idx;
    logic [D_SIZE-1:0]   snap_shift;
    logic [D_SIZE-1:0]   chan_word;

    always_comb begin
        boundary    = tick && frame_wrap;
        snap_d      = snap_q;
        cur_ch_d    = cur_ch_q;
        cur_win_d   = cur_win_q;
        fc_d        = fc_q;
        active_d    = active_q;
        auto_prev_d = auto_en;
        bnd_d       = boundary;
        chan_word   = '0;

        if (boundary) begin
            active_d = 1'b1;
            if (!auto_en) begin
                cur_ch_d  = (32'(ch_sel) >= N_CH) ? '0 : ch_sel;
                cur_win_d = (32'(win_sel) >= N_WIN) ? '0 : win_sel;
            end else if (fc_q == FC_LAST) begin
                fc_d = '0;
                if (cur_win_q == WIN_LAST) begin
                    cur_win_d = '0;
                    if (auto_ch) begin
                        cur_ch_d = (cur_ch_q == CH_LAST) ? '0 : cur_ch_q + 1'b1;
                    end
                end else begin
                    cur_win_d = cur_win_q + 1'b1;
                end
            end else begin
                fc_d = fc_q + 1'b1;
            end
            chan_word = D_SIZE'(ch_data >> (32'(cur_ch_d) * D_SIZE));
            if (!freeze) begin
                snap_d = chan_word;
            end
        end

        // Entering auto mode restarts the hold count from the current view.
        if (auto_en && !auto_prev_q) begin
            fc_d = '0;
        end

        // Display registers trail the scan index by one cycle; they use the
        // snapshot captured at the boundary, hence the one-cycle pulse delay.
        nib_idx    = 32'(cur_win_q) * N_DIGITS + 32'(d);
        snap_shift = snap_q >> (4 * nib_idx);
        fs_d       = bnd_q;
        if (active_q) begin
            an_d  = ~(N_DIGITS'(1) << d);
            seg_d = hex7seg(snap_shift[3:0]);
        end else begin
            an_d  = '1;
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q      <= '0;
            cur_ch_q    <= '0;
            cur_win_q   <= '0;
            fc_q        <= '0;
            auto_prev_q <= 1'b0;
            active_q    <= 1'b0;
            bnd_q       <= 1'b0;
            an_q        <= '1;
            seg_q       <= SEG_BLANK;
            fs_q        <= 1'b0;
        end else begin
            snap_q      <= snap_d;
            cur_ch_q    <= cur_ch_d;
            cur_win_q   <= cur_win_d;
            fc_q        <= fc_d;
            auto_prev_q <= auto_prev_d;
            active_q    <= active_d;
            bnd_q       <= bnd_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            fs_q        <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign cur_ch      = cur_ch_q;
    assign cur_win     = cur_win_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_probe_display_ctrl.sv
// Directed bench for probe_display_ctrl: a 4-channel instance for the main
// function and a 3-channel instance for the out-of-range channel select.
module tb_probe_display_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ch0_v, ch1_v, ch2_v, ch3_v;
    logic [127:0] ch_data;
    logic [95:0]  ch_data_b;
    logic [1:0]  ch_sel;
    logic [1:0]  ch_sel_b;
    logic        win_sel;
    logic        auto_en, auto_ch, freeze;

    logic [6:0]  seg, seg_b;
    logic [3:0]  an, an_b;
    logic [1:0]  cur_ch, cur_ch_b;
    logic        cur_win, cur_win_b;
    logic        fs, fs_b;

    int total = 0;
    int bad   = 0;

    assign ch_data   = {ch3_v, ch2_v, ch1_v, ch0_v};
    assign ch_data_b = {ch2_v, ch1_v, ch0_v};

    always #5 clk = ~clk;

    probe_display_ctrl #(
        .D_SIZE(32), .N_CH(4), .N_DIGITS(4), .REFRESH_DIV(2), .HOLD_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .ch_sel(ch_sel),
        .win_sel(win_sel), .auto_en(auto_en), .auto_ch(auto_ch),
        .freeze(freeze), .seg(seg), .an(an), .cur_ch(cur_ch),
        .cur_win(cur_win), .frame_start(fs)
    );

    probe_display_ctrl #(
        .D_SIZE(32), .N_CH(3), .N_DIGITS(4), .REFRESH_DIV(2), .HOLD_FRAMES(2)
    ) dut_b (
        .clk(clk), .rst(rst), .ch_data(ch_data_b), .ch_sel(ch_sel_b),
        .win_sel(win_sel), .auto_en(auto_en), .auto_ch(auto_ch),
        .freeze(freeze), .seg(seg_b), .an(an_b), .cur_ch(cur_ch_b),
        .cur_win(cur_win_b), .frame_start(fs_b)
    );

    typedef struct {
        logic [1:0] ch;
        logic       win;
        logic [1:0] ch_b;
        logic [6:0] s0, s1, s2, s3;
        logic [1:0] exp_ch_b;
        string      nm;
    } vec_t;

    vec_t vecs [8];
    logic [6:0] d0_tab [4][2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called in the frame_start cycle; checks all 8 cycles of the frame and
    // returns in the frame_start cycle of the following frame.
    task automatic check_frame(input logic [6:0] e0, e1, e2, e3,
                               input string nm, input bit mid_clear);
        logic [6:0] e [4];
        logic [3:0] exp_an;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < 8; i++) begin
            if (mid_clear && i == 4) ch1_v = '0;
            exp_an = 4'hF ^ (4'h1 << (i / 2));
            chk({nm, " an"}, 32'(an), 32'(exp_an));
            chk({nm, " seg"}, 32'(seg), 32'(e[i / 2]));
            chk({nm, " frame_start"}, 32'(fs), (i == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd1, 1'b1, 2'd3, 7'h40, 7'h0E, 7'h12, 7'h08, 2'd0, "v_ch1_w1"};
        vecs[1] = '{2'd1, 1'b0, 2'd2, 7'h19, 7'h30, 7'h24, 7'h79, 2'd2, "v_ch1_w0"};
        vecs[2] = '{2'd2, 1'b0, 2'd3, 7'h0E, 7'h06, 7'h21, 7'h46, 2'd0, "v_ch2_w0"};
        vecs[3] = '{2'd2, 1'b1, 2'd1, 7'h03, 7'h08, 7'h10, 7'h00, 2'd1, "v_ch2_w1"};
        vecs[4] = '{2'd3, 1'b0, 2'd0, 7'h40, 7'h79, 7'h24, 7'h30, 2'd0, "v_ch3_w0"};
        vecs[5] = '{2'd3, 1'b1, 2'd3, 7'h19, 7'h12, 7'h02, 7'h78, 2'd0, "v_ch3_w1"};
        vecs[6] = '{2'd0, 1'b1, 2'd2, 7'h79, 7'h79, 7'h79, 7'h79, 2'd2, "v_ch0_w1"};
        vecs[7] = '{2'd0, 1'b0, 2'd1, 7'h40, 7'h40, 7'h40, 7'h40, 2'd1, "v_ch0_w0"};

        // digit-0 pattern of each (channel, window) in the auto sequence
        d0_tab[0][0] = 7'h40; d0_tab[0][1] = 7'h79;
        d0_tab[1][0] = 7'h30; d0_tab[1][1] = 7'h24;
        d0_tab[2][0] = 7'h0E; d0_tab[2][1] = 7'h03;
        d0_tab[3][0] = 7'h40; d0_tab[3][1] = 7'h19;

        ch0_v = 32'h1111_0000; ch1_v = 32'hA5F0_1234;
        ch2_v = 32'h89AB_CDEF; ch3_v = 32'h7654_3210;
        ch_sel = vecs[0].ch; win_sel = vecs[0].win; ch_sel_b = vecs[0].ch_b;
        auto_en = 1'b0; auto_ch = 1'b0; freeze = 1'b0;

        // reset
        rst = 1'b1;
        step(3);
        chk("rst an", 32'(an), 32'hF);
        chk("rst seg", 32'(seg), 32'h7F);
        chk("rst cur_ch", 32'(cur_ch), 0);
        chk("rst cur_win", 32'(cur_win), 0);
        chk("rst frame_start", 32'(fs), 0);
        chk("rst an_b", 32'(an_b), 32'hF);
        rst = 1'b0;
        step(2);
        chk("latency blank at cycle 2", 32'(an), 32'hF);
        step(1);

        // manual vectors
        for (int v = 0; v < 8; v++) begin
            ch_sel = vecs[v].ch; win_sel = vecs[v].win; ch_sel_b = vecs[v].ch_b;
            if (v > 0) step(8);
            chk({vecs[v].nm, " cur_ch"}, 32'(cur_ch), 32'(vecs[v].ch));
            chk({vecs[v].nm, " cur_win"}, 32'(cur_win), 32'(vecs[v].win));
            chk({vecs[v].nm, " cur_ch_b"}, 32'(cur_ch_b), 32'(vecs[v].exp_ch_b));
            check_frame(vecs[v].s0, vecs[v].s1, vecs[v].s2, vecs[v].s3, vecs[v].nm, 1'b0);
        end

        // data change at digit 2 leaves the current frame intact
        ch_sel = 2'd1; win_sel = 1'b1;
        step(8);
        check_frame(7'h40, 7'h0E, 7'h12, 7'h08, "mid_frame", 1'b1);
        check_frame(7'h40, 7'h40, 7'h40, 7'h40, "mid_next", 1'b0);

        // auto scroll with channel advance
        ch1_v = 32'h2222_3333;
        ch_sel = 2'd0; win_sel = 1'b0;
        step(8);
        check_frame(7'h40, 7'h40, 7'h40, 7'h40, "auto_pre", 1'b0);
        auto_en = 1'b1; auto_ch = 1'b1;
        for (int f = 0; f < 16; f++) begin
            int idx;
            step(8);
            idx = (f + 1) / 2;
            chk($sformatf("auto f%0d cur_ch", f), 32'(cur_ch), 32'((idx / 2) % 4));
            chk($sformatf("auto f%0d cur_win", f), 32'(cur_win), 32'(idx % 2));
            chk($sformatf("auto f%0d seg", f), 32'(seg), 32'(d0_tab[(idx / 2) % 4][idx % 2]));
        end

        // freeze
        auto_en = 1'b0; auto_ch = 1'b0; freeze = 1'b1;
        step(8);
        check_frame(7'h40, 7'h40, 7'h40, 7'h40, "frz0", 1'b0);
        ch0_v = 32'h0000_5555;
        check_frame(7'h40, 7'h40, 7'h40, 7'h40, "frz1", 1'b0);
        check_frame(7'h40, 7'h40, 7'h40, 7'h40, "frz2", 1'b0);
        check_frame(7'h40, 7'h40, 7'h40, 7'h40, "frz3", 1'b0);
        win_sel = 1'b1;
        step(8);
        chk("frz win cur_win", 32'(cur_win), 1);
        check_frame(7'h79, 7'h79, 7'h79, 7'h79, "frz_win1", 1'b0);
        win_sel = 1'b0; freeze = 1'b0;
        step(8);
        check_frame(7'h12, 7'h12, 7'h12, 7'h12, "unfreeze", 1'b0);

        // reset in the middle of a frame
        step(4);
        rst = 1'b1;
        step(1);
        chk("midrst an", 32'(an), 32'hF);
        chk("midrst seg", 32'(seg), 32'h7F);
        chk("midrst frame_start", 32'(fs), 0);
        chk("midrst cur_ch", 32'(cur_ch), 0);
        chk("midrst cur_win", 32'(cur_win), 0);
        chk("midrst an_b", 32'(an_b), 32'hF);
        chk("midrst cur_ch_b", 32'(cur_ch_b), 0);
        rst = 1'b0;
        step(2);
        chk("midrst blank at cycle 2", 32'(an), 32'hF);
        step(1);
        chk("midrst first an", 32'(an), 32'hE);
        chk("midrst first frame_start", 32'(fs), 1);
        chk("midrst first seg", 32'(seg), 32'h12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
